// File: rtl/mmm_pkg.sv
// Shared types for the fetch path.
// Latency: n/a (types only).
// Backpressure: n/a.
package mmm_pkg;

  parameter int XLEN = 32;

  // One i-cache response beat: fetched word plus a fault flag.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            fault;
  } icache_out_t;

endpackage

// File: rtl/icache_arb_if.sv
// Bundle of request, cache and response handshakes around icache_arb.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel.
interface icache_arb_if;
  import mmm_pkg::*;

  logic              flush_i;
  logic [XLEN-1:0]   req0_addr_i;
  logic              req0_valid_i;
  logic              req0_ready_o;
  logic [XLEN-1:0]   req1_addr_i;
  logic              req1_valid_i;
  logic              req1_ready_o;
  logic [XLEN-1:0]   icache_addr_o;
  logic              icache_addr_valid_o;
  logic              icache_addr_ready_i;
  icache_out_t       icache_data_i;
  logic              icache_data_valid_i;
  logic              icache_data_ready_o;
  icache_out_t       rsp0_data_o;
  logic              rsp0_valid_o;
  logic              rsp0_ready_i;
  icache_out_t       rsp1_data_o;
  logic              rsp1_valid_o;
  logic              rsp1_ready_i;
  logic [2:0]        outst_o;
  logic              err_o;

  // Arbiter side.
  modport slave (
    input  flush_i,
    input  req0_addr_i, req0_valid_i, output req0_ready_o,
    input  req1_addr_i, req1_valid_i, output req1_ready_o,
    output icache_addr_o, icache_addr_valid_o, input icache_addr_ready_i,
    input  icache_data_i, icache_data_valid_i, output icache_data_ready_o,
    output rsp0_data_o, rsp0_valid_o, input rsp0_ready_i,
    output rsp1_data_o, rsp1_valid_o, input rsp1_ready_i,
    output outst_o, err_o
  );

  // Requesters / cache / environment side.
  modport master (
    output flush_i,
    output req0_addr_i, req0_valid_i, input req0_ready_o,
    output req1_addr_i, req1_valid_i, input req1_ready_o,
    input  icache_addr_o, icache_addr_valid_o, output icache_addr_ready_i,
    output icache_data_i, icache_data_valid_i, input icache_data_ready_o,
    input  rsp0_data_o, rsp0_valid_o, output rsp0_ready_i,
    input  rsp1_data_o, rsp1_valid_o, output rsp1_ready_i,
    input  outst_o, err_o
  );

endinterface

// File: rtl/icache_arb.sv
// Round-robin arbiter of two fetch requesters onto one i-cache port, in-order response routing.
// Latency: address path combinational; responses routed combinationally from the cache.
// Backpressure: grant held (locked) under cache stall; no grant when MAX_OUTST in flight or flushing.
module icache_arb #(
  parameter int MAX_OUTST = 2
) (
  input logic         clk_i,
  input logic         rst_i,
  icache_arb_if.slave bus
);

  localparam int            PW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam logic [2:0]    MAX_C = 3'(MAX_OUTST);
  localparam logic [PW-1:0] LAST  = PW'(MAX_OUTST - 1);

  logic [2:0]    cnt_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic          id_q   [MAX_OUTST];
  logic          kill_q [MAX_OUTST];
  logic          rr_last_q;   // requester granted on the last address handshake
  logic          lock_q;
  logic          lock_id_q;

  logic gnt, req_vld, eligible, addr_hs;
  logic empty, head_id, head_kill, drain, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Pick requester: held grant first, otherwise round-robin between valid requesters.
  always_comb begin
    gnt = 1'b0;
    if (lock_q) begin
      gnt = lock_id_q;
    end else if (bus.req0_valid_i && bus.req1_valid_i) begin
      gnt = ~rr_last_q;
    end else if (bus.req1_valid_i) begin
      gnt = 1'b1;
    end
  end

  // Only the registered count gates grants, so a slot freed this cycle is not reused until next cycle.
  assign req_vld                 = gnt ? bus.req1_valid_i : bus.req0_valid_i;
  assign eligible                = !rst_i && !bus.flush_i && (cnt_q < MAX_C);
  assign bus.icache_addr_valid_o = eligible && req_vld;
  assign bus.icache_addr_o       = gnt ? bus.req1_addr_i : bus.req0_addr_i;
  assign bus.req0_ready_o        = eligible && !gnt && bus.icache_addr_ready_i;
  assign bus.req1_ready_o        = eligible &&  gnt && bus.icache_addr_ready_i;
  assign addr_hs                 = bus.icache_addr_valid_o && bus.icache_addr_ready_i;

  assign empty     = (cnt_q == 3'd0);
  assign head_id   = id_q[rd_ptr_q];
  assign head_kill = kill_q[rd_ptr_q];
  // Killed or flushed responses are swallowed without reaching either requester.
  assign drain     = !empty && (head_kill || bus.flush_i);

  // Route the head response to its requester, or drain it.
  always_comb begin
    bus.icache_data_ready_o = 1'b0;
    if (!rst_i && !empty) begin
      if (drain) bus.icache_data_ready_o = 1'b1;
      else       bus.icache_data_ready_o = head_id ? bus.rsp1_ready_i : bus.rsp0_ready_i;
    end
  end

  assign bus.rsp0_valid_o = !rst_i && !empty && !drain && bus.icache_data_valid_i && !head_id;
  assign bus.rsp1_valid_o = !rst_i && !empty && !drain && bus.icache_data_valid_i &&  head_id;
  assign bus.rsp0_data_o  = bus.icache_data_i;
  assign bus.rsp1_data_o  = bus.icache_data_i;
  assign pop              = bus.icache_data_valid_i && bus.icache_data_ready_o;

  assign bus.outst_o = cnt_q;

  // Tracking FIFO, occupancy count and sticky protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      bus.err_o <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        id_q[i]   <= 1'b0;
        kill_q[i] <= 1'b0;
      end
    end else begin
      if (bus.flush_i) begin
        for (int i = 0; i < MAX_OUTST; i++) kill_q[i] <= 1'b1;
      end
      if (addr_hs) begin
        id_q[wr_ptr_q]   <= gnt;
        kill_q[wr_ptr_q] <= 1'b0;
        wr_ptr_q         <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (addr_hs && !pop)      cnt_q <= cnt_q + 3'd1;
      else if (!addr_hs && pop) cnt_q <= cnt_q - 3'd1;
      if (bus.icache_data_valid_i && empty) bus.err_o <= 1'b1;
    end
  end

  // Round-robin pointer and stall lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_last_q <= 1'b1;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      if (addr_hs) rr_last_q <= gnt;
      if (addr_hs || bus.flush_i) begin
        lock_q <= 1'b0;
      end else if (bus.icache_addr_valid_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_icache_arb.sv
// Directed self-checking bench for icache_arb (MAX_OUTST = 2).
// Latency: n/a.
// Backpressure: exercised via icache_addr_ready_i and held responses.
module tb_icache_arb;
  import mmm_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  icache_arb_if bus ();

  icache_arb #(.MAX_OUTST(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic icache_out_t dat(input logic [XLEN-1:0] a);
    icache_out_t d;
    d.data  = a ^ 32'hA5A5_0000;
    d.fault = a[2];
    return d;
  endfunction

  task automatic set_req(input logic v0, input logic [31:0] a0, input logic v1, input logic [31:0] a1);
    bus.req0_valid_i = v0; bus.req0_addr_i = a0;
    bus.req1_valid_i = v1; bus.req1_addr_i = a1;
  endtask

  task automatic set_rsp(input logic v, input logic [31:0] a);
    bus.icache_data_valid_i = v;
    bus.icache_data_i       = dat(a);
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v0, input logic v1, input logic [31:0] a);
    check({tag, "_rsp0_vld"}, 64'(bus.rsp0_valid_o), 64'(v0));
    check({tag, "_rsp1_vld"}, 64'(bus.rsp1_valid_o), 64'(v1));
    if (v0) check({tag, "_rsp0_dat"}, 64'(bus.rsp0_data_o), 64'(dat(a)));
    if (v1) check({tag, "_rsp1_dat"}, 64'(bus.rsp1_data_o), 64'(dat(a)));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    nxt();
    nxt();
    rst_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a0_q [3];
    logic [31:0] ga;

    bus.flush_i = 1'b0;
    bus.icache_addr_ready_i = 1'b1;
    bus.rsp0_ready_i = 1'b1;
    bus.rsp1_ready_i = 1'b1;
    set_req(1'b1, 32'h0, 1'b1, 32'h4);
    set_rsp(1'b1, 32'h0);

    // Reset: outputs idle even with live inputs.
    nxt();
    #1;
    check("rst_addr_vld", 64'(bus.icache_addr_valid_o), 64'd0);
    check("rst_req0_rdy", 64'(bus.req0_ready_o), 64'd0);
    check("rst_req1_rdy", 64'(bus.req1_ready_o), 64'd0);
    check("rst_data_rdy", 64'(bus.icache_data_ready_o), 64'd0);
    chk_rsp("rst", 1'b0, 1'b0, 32'h0);
    check("rst_outst", 64'(bus.outst_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    set_rsp(1'b0, 32'h0);
    nxt();
    rst_i = 1'b0;

    // Single requester, back-to-back with one-cycle responses.
    a0_q[0] = 32'h0; a0_q[1] = 32'h4; a0_q[2] = 32'h8;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_req(1'b1, a0_q[i], 1'b0, 32'h0);
      else       set_req(1'b0, 32'h0, 1'b0, 32'h0);
      if (i > 0) set_rsp(1'b1, a0_q[i-1]);
      else       set_rsp(1'b0, 32'h0);
      #1;
      if (i < 3) begin
        check("single_addr", 64'(bus.icache_addr_o), 64'(a0_q[i]));
        check("single_rdy0", 64'(bus.req0_ready_o), 64'd1);
      end
      if (i > 0) chk_rsp("single", 1'b1, 1'b0, a0_q[i-1]);
      check("single_outst", 64'(bus.outst_o), (i == 0) ? 64'd0 : 64'd1);
      nxt();
    end
    set_rsp(1'b0, 32'h0);
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("single_outst_end", 64'(bus.outst_o), 64'd0);

    // Both requesters valid every cycle: grants alternate starting with requester 0.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_req(1'b1, 32'h100 + 32'(i * 16), 1'b1, 32'h200 + 32'(i * 16));
      else       set_req(1'b0, 32'h0, 1'b0, 32'h0);
      if (i > 0) begin
        ga = ((i - 1) % 2 == 0) ? 32'h100 + 32'((i - 1) * 16) : 32'h200 + 32'((i - 1) * 16);
        set_rsp(1'b1, ga);
      end else begin
        set_rsp(1'b0, 32'h0);
      end
      #1;
      if (i < 4) begin
        check("rr_addr", 64'(bus.icache_addr_o),
              (i % 2 == 0) ? 64'(32'h100 + 32'(i * 16)) : 64'(32'h200 + 32'(i * 16)));
        check("rr_rdy0", 64'(bus.req0_ready_o), 64'(i % 2 == 0));
        check("rr_rdy1", 64'(bus.req1_ready_o), 64'(i % 2 == 1));
      end
      if (i > 0) chk_rsp("rr", ((i - 1) % 2 == 0), ((i - 1) % 2 == 1), ga);
      nxt();
    end
    set_rsp(1'b0, 32'h0);

    // Backpressure with lock, then full condition.
    do_reset();
    set_req(1'b1, 32'h3C, 1'b0, 32'h0);
    #1; check("bp_c0_rdy0", 64'(bus.req0_ready_o), 64'd1);
    nxt();
    set_req(1'b1, 32'h40, 1'b0, 32'h0);
    bus.icache_addr_ready_i = 1'b0;
    set_rsp(1'b1, 32'h3C);
    #1;
    check("bp_c1_addr", 64'(bus.icache_addr_o), 64'h40);
    check("bp_c1_rdy0", 64'(bus.req0_ready_o), 64'd0);
    chk_rsp("bp_c1", 1'b1, 1'b0, 32'h3C);
    nxt();
    set_rsp(1'b0, 32'h0);
    set_req(1'b1, 32'h40, 1'b1, 32'h80);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bp_lock_addr", 64'(bus.icache_addr_o), 64'h40);
      check("bp_lock_vld", 64'(bus.icache_addr_valid_o), 64'd1);
      check("bp_lock_rdy1", 64'(bus.req1_ready_o), 64'd0);
      nxt();
    end
    bus.icache_addr_ready_i = 1'b1;
    #1;
    check("bp_acc_addr", 64'(bus.icache_addr_o), 64'h40);
    check("bp_acc_rdy0", 64'(bus.req0_ready_o), 64'd1);
    check("bp_acc_rdy1", 64'(bus.req1_ready_o), 64'd0);
    nxt();
    set_req(1'b1, 32'h44, 1'b1, 32'h80);
    #1;
    check("bp_next_addr", 64'(bus.icache_addr_o), 64'h80);
    check("bp_next_rdy1", 64'(bus.req1_ready_o), 64'd1);
    check("bp_next_rdy0", 64'(bus.req0_ready_o), 64'd0);
    nxt();
    set_req(1'b1, 32'h44, 1'b0, 32'h0);
    #1;
    check("full_outst", 64'(bus.outst_o), 64'd2);
    check("full_rdy0", 64'(bus.req0_ready_o), 64'd0);
    check("full_addr_vld", 64'(bus.icache_addr_valid_o), 64'd0);
    nxt();
    set_rsp(1'b1, 32'h40);
    #1;
    chk_rsp("full_pop", 1'b1, 1'b0, 32'h40);
    check("full_pop_rdy0", 64'(bus.req0_ready_o), 64'd0);
    nxt();
    set_rsp(1'b1, 32'h80);
    #1;
    check("full_after_rdy0", 64'(bus.req0_ready_o), 64'd1);
    check("full_after_outst", 64'(bus.outst_o), 64'd1);
    chk_rsp("full_after", 1'b0, 1'b1, 32'h80);
    nxt();
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    set_rsp(1'b1, 32'h44);
    #1;
    chk_rsp("full_last", 1'b1, 1'b0, 32'h44);
    nxt();
    set_rsp(1'b0, 32'h0);

    // Flush with two in flight: both responses drained silently.
    set_req(1'b1, 32'h10, 1'b0, 32'h0);
    nxt();
    set_req(1'b0, 32'h0, 1'b1, 32'h20);
    #1; check("fl_rdy1", 64'(bus.req1_ready_o), 64'd1);
    nxt();
    set_req(1'b1, 32'h30, 1'b0, 32'h0);
    bus.flush_i = 1'b1;
    #1;
    check("fl_addr_vld", 64'(bus.icache_addr_valid_o), 64'd0);
    check("fl_rdy0", 64'(bus.req0_ready_o), 64'd0);
    check("fl_data_rdy", 64'(bus.icache_data_ready_o), 64'd1);
    nxt();
    bus.flush_i = 1'b0;
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    set_rsp(1'b1, 32'h10);
    #1;
    check("fl_d1_outst", 64'(bus.outst_o), 64'd2);
    check("fl_d1_rdy", 64'(bus.icache_data_ready_o), 64'd1);
    chk_rsp("fl_d1", 1'b0, 1'b0, 32'h0);
    nxt();
    set_rsp(1'b1, 32'h20);
    #1;
    check("fl_d2_outst", 64'(bus.outst_o), 64'd1);
    check("fl_d2_rdy", 64'(bus.icache_data_ready_o), 64'd1);
    chk_rsp("fl_d2", 1'b0, 1'b0, 32'h0);
    nxt();
    set_rsp(1'b0, 32'h0);
    set_req(1'b1, 32'h30, 1'b0, 32'h0);
    #1;
    check("fl_after_outst", 64'(bus.outst_o), 64'd0);
    check("fl_after_rdy0", 64'(bus.req0_ready_o), 64'd1);
    nxt();
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    set_rsp(1'b1, 32'h30);
    #1;
    chk_rsp("fl_after", 1'b1, 1'b0, 32'h30);
    nxt();

    // Spurious response while empty: sticky error, then reset mid-flight.
    set_rsp(1'b1, 32'h99);
    #1;
    check("sp_data_rdy", 64'(bus.icache_data_ready_o), 64'd0);
    chk_rsp("sp", 1'b0, 1'b0, 32'h0);
    nxt();
    set_rsp(1'b0, 32'h0);
    #1; check("sp_err1", 64'(bus.err_o), 64'd1);
    set_req(1'b1, 32'h50, 1'b0, 32'h0);
    nxt();
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("sp_err2", 64'(bus.err_o), 64'd1);
    check("mid_outst", 64'(bus.outst_o), 64'd1);
    rst_i = 1'b1;
    set_req(1'b1, 32'h54, 1'b0, 32'h0);
    set_rsp(1'b1, 32'h50);
    #1;
    check("mid_rst_addr_vld", 64'(bus.icache_addr_valid_o), 64'd0);
    check("mid_rst_data_rdy", 64'(bus.icache_data_ready_o), 64'd0);
    chk_rsp("mid_rst", 1'b0, 1'b0, 32'h0);
    nxt();
    rst_i = 1'b0;
    set_req(1'b0, 32'h0, 1'b0, 32'h0);
    set_rsp(1'b0, 32'h0);
    #1;
    check("mid_after_outst", 64'(bus.outst_o), 64'd0);
    check("mid_after_err", 64'(bus.err_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
